rename_multi: RTL and testbench
===============================

Name: rename_multi

Overview:
- Parametrised multi-wide successor to the single-issue rename stage.
- Renames up to WIDTH instructions per cycle, with intra-group dependency bypass and old-tag reporting for retire-time freeing.
- Maintains a speculative RAT and an architectural (retirement) RAT so a flush restores precise mapping state in one cycle.
- Sits between decode and issue queue / load-store unit.

Parameters:
NUM_REG, 32, architectural registers (x0 hardwired)
NUM_TAGS, 64, physical tags; must exceed NUM_REG
WIDTH, 2, rename slots per cycle (1..4)
RETIRE_WIDTH, 2, retire ports per cycle (1..4)
NUM_REG_LOG2, $clog2(NUM_REG), derived
NUM_TAGS_LOG2, $clog2(NUM_TAGS), derived

Ports:
clk  in  1  clock; all state on rising edge
rst  in  1  asynchronous, active-low reset
stall_in  in  1  downstream cannot accept a group this cycle
flush  in  1  mispredict/exception; restore from architectural RAT
in_valid  in  WIDTH  per-slot instruction valid; slots packed from slot 0
opcode  in  [WIDTH][7]  per-slot opcode
rd, rs1, rs2  in  [WIDTH][NUM_REG_LOG2]  per-slot architectural registers
in_ready  out  1  group accepted this cycle (combinational)
retire_valid  in  RETIRE_WIDTH  per-port retire strobe, in program order
retire_rd  in  [RETIRE_WIDTH][NUM_REG_LOG2]  retiring destination
retire_tag  in  [RETIRE_WIDTH][NUM_TAGS_LOG2]  tag committed to retire_rd
retire_old_tag  in  [RETIRE_WIDTH][NUM_TAGS_LOG2]  previous mapping to free
out_valid  out  WIDTH  registered per-slot valid
tag_rd, tag_rs1, tag_rs2, tag_old_rd  out  [WIDTH][NUM_TAGS_LOG2]  registered renamed tags
load_store  out  WIDTH  slot is load (0000011) or store (0100011)
free_count  out  NUM_TAGS_LOG2+1  number of free tags (registered)

Behaviour:
- Reset (rst low, async):
  - Both RATs set to identity: RAT[i]=i.
  - Free pool: tags 0..NUM_REG-1 busy, tags NUM_REG..NUM_TAGS-1 free.
  - free_count = NUM_TAGS-NUM_REG.
  - All out_* and load_store cleared to 0.
  - Reset mid-group discards the group.
- Slot needs allocation iff in_valid[s] && rd[s]!=0.
- Acceptance: in_ready = ~flush & ~stall_in & (free_count >= number of allocating slots).
  - All-or-nothing: no partial groups.
  - in_valid all-zero with in_ready high consumes nothing.
- Allocation: allocating slots, in slot order, take free tags in ascending index order (lowest free tag to lowest slot).
- Sources and old tag for slot s:
  - Each is taken from the youngest earlier valid slot j<s with rd[j]==that register and rd[j]!=0, using that slot's new tag.
  - Otherwise taken from the speculative RAT.
  - Any register 0 yields tag 0.
  - Non-allocating slots output tag_rd=0 and tag_old_rd=0.
- On accept, the following happen at the next edge:
  - Speculative RAT written (youngest writer wins for duplicate rd).
  - Allocated tags cleared from the free pool.
  - Outputs registered with out_valid=in_valid. Latency: 1 cycle.
- If not accepted, out_valid=0 next cycle; outputs other than valid are don't-care but must not X.
- Retire (every cycle, independent of stall):
  - For each valid port in port order: archRAT[retire_rd] <= retire_tag; later port wins.
  - retire_old_tag set free unless it is 0.
  - retire_rd==0 ignored.
  - Freed tags are visible in the free pool and free_count the cycle after; no same-cycle bypass into allocation.
- Tag 0 is never allocated and never freed.
- Flush (highest priority):
  - No accept (in_ready=0).
  - Speculative RAT <= archRAT including same-cycle retire updates.
  - Free pool <= every tag not referenced by the updated archRAT.
  - free_count recomputed to match.
  - out_valid=0 next cycle.
- free_count always equals popcount(free pool); never underflows, since acceptance guarantees enough free tags.
- load_store[s] = in_valid[s] & opcode match, registered with the group.

Test Plan:
- Reset with rst low mid-cycle, then release -> tag_rs1 for rs1=5 is 5; free_count=32; out_valid=0.
- Group {add x3,x1,x2 ; add x4,x3,x3} -> slot0 tag_rd=32, tag_old_rd=3; slot1 tag_rs1=tag_rs2=32, tag_rd=33, tag_old_rd=4; free_count=30.
- Same rd in both slots (x7, x7) -> tags 32/33; slot1 tag_old_rd=32; RAT[7]=33 next group.
- Drain to free_count=1, present two allocating slots -> in_ready=0, no state change. Same cycle retire frees tag 40 -> free_count=2 next cycle, then group accepted with tags {lowest two free}.
- Rename x5->32, x6->33, retire only x5 (tag 32, old 5), assert flush -> next group reads x5=32, x6=6; tag 33 free; free_count=32.
- Slot with rd=0 (store, opcode 0100011) -> tag_rd=0, load_store=1, no allocation; retire_old_tag=0 never frees tag 0.

Source files
------------

// File: rtl/rename_multi.sv
// ---------------------------------------------------------------------------
// rename_multi
//
// Multi-wide register rename stage. Up to WIDTH instructions are renamed per
// cycle with intra-group dependency bypass. A speculative RAT is used for
// renaming. An architectural RAT is updated by the retire ports, so a flush
// restores precise mapping state in a single cycle.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   stall_in          downstream cannot take a group this cycle
//   flush             restore speculative state from the architectural RAT
//   in_valid          per-slot valid, packed from slot 0
//   opcode/rd/rs1/rs2 per-slot decoded fields
//   in_ready          group accepted this cycle (combinational)
//   retire_*          per-port retire strobe, destination, new tag, old tag
//   out_valid         registered per-slot valid of the renamed group
//   tag_rd/rs1/rs2    registered physical tags for the group
//   tag_old_rd        previous mapping of rd, freed when the slot retires
//   load_store        registered per-slot load/store flag
//   free_count        registered count of free physical tags
// ---------------------------------------------------------------------------
module rename_multi #(
    parameter int NUM_REG       = 32,
    parameter int NUM_TAGS      = 64,
    parameter int WIDTH         = 2,
    parameter int RETIRE_WIDTH  = 2,
    parameter int NUM_REG_LOG2  = $clog2(NUM_REG),
    parameter int NUM_TAGS_LOG2 = $clog2(NUM_TAGS)
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          stall_in,
    input  logic                                          flush,
    input  logic [WIDTH-1:0]                              in_valid,
    input  logic [WIDTH-1:0][6:0]                         opcode,
    input  logic [WIDTH-1:0][NUM_REG_LOG2-1:0]            rd,
    input  logic [WIDTH-1:0][NUM_REG_LOG2-1:0]            rs1,
    input  logic [WIDTH-1:0][NUM_REG_LOG2-1:0]            rs2,
    output logic                                          in_ready,
    input  logic [RETIRE_WIDTH-1:0]                       retire_valid,
    input  logic [RETIRE_WIDTH-1:0][NUM_REG_LOG2-1:0]     retire_rd,
    input  logic [RETIRE_WIDTH-1:0][NUM_TAGS_LOG2-1:0]    retire_tag,
    input  logic [RETIRE_WIDTH-1:0][NUM_TAGS_LOG2-1:0]    retire_old_tag,
    output logic [WIDTH-1:0]                              out_valid,
    output logic [WIDTH-1:0][NUM_TAGS_LOG2-1:0]           tag_rd,
    output logic [WIDTH-1:0][NUM_TAGS_LOG2-1:0]           tag_rs1,
    output logic [WIDTH-1:0][NUM_TAGS_LOG2-1:0]           tag_rs2,
    output logic [WIDTH-1:0][NUM_TAGS_LOG2-1:0]           tag_old_rd,
    output logic [WIDTH-1:0]                              load_store,
    output logic [NUM_TAGS_LOG2:0]                        free_count
);

    localparam int TW = NUM_TAGS_LOG2;
    localparam int CW = NUM_TAGS_LOG2 + 1;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    // Architectural state
    logic [TW-1:0]        spec_rat_q [NUM_REG];
    logic [TW-1:0]        spec_rat_d [NUM_REG];
    logic [TW-1:0]        arch_rat_q [NUM_REG];
    logic [TW-1:0]        arch_rat_d [NUM_REG];
    logic [NUM_TAGS-1:0]  free_q;
    logic [NUM_TAGS-1:0]  free_d;
    logic [CW-1:0]        free_count_q;
    logic [CW-1:0]        free_count_d;

    // Registered group outputs
    logic [WIDTH-1:0]          out_valid_q,  out_valid_d;
    logic [WIDTH-1:0][TW-1:0]  tag_rd_q,     tag_rd_d;
    logic [WIDTH-1:0][TW-1:0]  tag_rs1_q,    tag_rs1_d;
    logic [WIDTH-1:0][TW-1:0]  tag_rs2_q,    tag_rs2_d;
    logic [WIDTH-1:0][TW-1:0]  tag_old_rd_q, tag_old_rd_d;
    logic [WIDTH-1:0]          load_store_q, load_store_d;

    // Combinational helpers
    logic [WIDTH-1:0]          alloc;
    logic [CW-1:0]             num_alloc;
    logic [WIDTH-1:0][TW-1:0]  new_tag;
    logic [NUM_TAGS-1:0]       avail;
    logic [NUM_TAGS-1:0]       alloc_mask;
    logic                      found;
    logic [NUM_TAGS-1:0]       retire_free;
    logic [NUM_TAGS-1:0]       referenced;

    // A slot allocates only when it is valid and writes a real register.
    // The group is taken all-or-nothing, so the whole group's demand is
    // compared against the registered free count.
    always_comb begin
        alloc     = '0;
        num_alloc = '0;
        for (int s = 0; s < WIDTH; s++) begin
            alloc[s]  = in_valid[s] && (rd[s] != '0);
            num_alloc = num_alloc + CW'(alloc[s]);
        end
        in_ready = ~flush & ~stall_in & (free_count_q >= num_alloc);
    end

    // Lowest free tag goes to the lowest allocating slot. Tag 0 is masked
    // out so it can never be handed out even if the pool were corrupted.
    always_comb begin
        avail      = free_q;
        avail[0]   = 1'b0;
        alloc_mask = '0;
        new_tag    = '0;
        found      = 1'b0;
        for (int s = 0; s < WIDTH; s++) begin
            found = 1'b0;
            if (alloc[s]) begin
                for (int t = 1; t < NUM_TAGS; t++) begin
                    if (!found && avail[t]) begin
                        new_tag[s]    = TW'(t);
                        avail[t]      = 1'b0;
                        alloc_mask[t] = 1'b1;
                        found         = 1'b1;
                    end
                end
            end
        end
    end

    // Source and old-destination lookup. An earlier allocating slot in the
    // same group overrides the RAT; iterating j upward leaves the youngest
    // matching writer in place.
    always_comb begin
        tag_rs1_d    = '0;
        tag_rs2_d    = '0;
        tag_old_rd_d = '0;
        tag_rd_d     = '0;
        load_store_d = '0;
        for (int s = 0; s < WIDTH; s++) begin
            tag_rs1_d[s]    = spec_rat_q[rs1[s]];
            tag_rs2_d[s]    = spec_rat_q[rs2[s]];
            tag_old_rd_d[s] = spec_rat_q[rd[s]];
            for (int j = 0; j < s; j++) begin
                if (alloc[j]) begin
                    if (rd[j] == rs1[s]) tag_rs1_d[s]    = new_tag[j];
                    if (rd[j] == rs2[s]) tag_rs2_d[s]    = new_tag[j];
                    if (rd[j] == rd[s])  tag_old_rd_d[s] = new_tag[j];
                end
            end
            if (rs1[s] == '0) tag_rs1_d[s] = '0;
            if (rs2[s] == '0) tag_rs2_d[s] = '0;
            if (!alloc[s])    tag_old_rd_d[s] = '0;
            tag_rd_d[s]     = alloc[s] ? new_tag[s] : '0;
            load_store_d[s] = in_valid[s] &&
                              ((opcode[s] == OPC_LOAD) || (opcode[s] == OPC_STORE));
        end
        out_valid_d = in_ready ? in_valid : '0;
    end

    // Next-state for both RATs and the free pool. Retire always updates the
    // architectural RAT; a port with retire_rd==0 carries nothing and is
    // ignored entirely. Flush rebuilds the free pool from the post-retire
    // architectural RAT, which also absorbs any same-cycle frees.
    always_comb begin
        arch_rat_d  = arch_rat_q;
        retire_free = '0;
        for (int p = 0; p < RETIRE_WIDTH; p++) begin
            if (retire_valid[p] && (retire_rd[p] != '0)) begin
                arch_rat_d[retire_rd[p]] = retire_tag[p];
                if (retire_old_tag[p] != '0) begin
                    retire_free[retire_old_tag[p]] = 1'b1;
                end
            end
        end

        spec_rat_d = spec_rat_q;
        free_d     = free_q | retire_free;
        referenced = '0;

        if (flush) begin
            spec_rat_d = arch_rat_d;
            for (int r = 0; r < NUM_REG; r++) begin
                referenced[arch_rat_d[r]] = 1'b1;
            end
            free_d = ~referenced;
        end else if (in_ready) begin
            for (int s = 0; s < WIDTH; s++) begin
                if (alloc[s]) begin
                    spec_rat_d[rd[s]] = new_tag[s];
                end
            end
            free_d = free_d & ~alloc_mask;
        end
        free_d[0] = 1'b0;

        free_count_d = '0;
        for (int t = 0; t < NUM_TAGS; t++) begin
            free_count_d = free_count_d + CW'(free_d[t]);
        end
    end

    // State register. Reset puts both RATs at identity and frees every tag
    // above the architectural range.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < NUM_REG; r++) begin
                spec_rat_q[r] <= TW'(r);
                arch_rat_q[r] <= TW'(r);
            end
            for (int t = 0; t < NUM_TAGS; t++) begin
                free_q[t] <= (t >= NUM_REG);
            end
            free_count_q <= CW'(NUM_TAGS - NUM_REG);
            out_valid_q  <= '0;
            tag_rd_q     <= '0;
            tag_rs1_q    <= '0;
            tag_rs2_q    <= '0;
            tag_old_rd_q <= '0;
            load_store_q <= '0;
        end else begin
            spec_rat_q   <= spec_rat_d;
            arch_rat_q   <= arch_rat_d;
            free_q       <= free_d;
            free_count_q <= free_count_d;
            out_valid_q  <= out_valid_d;
            tag_rd_q     <= tag_rd_d;
            tag_rs1_q    <= tag_rs1_d;
            tag_rs2_q    <= tag_rs2_d;
            tag_old_rd_q <= tag_old_rd_d;
            load_store_q <= load_store_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign tag_rd     = tag_rd_q;
    assign tag_rs1    = tag_rs1_q;
    assign tag_rs2    = tag_rs2_q;
    assign tag_old_rd = tag_old_rd_q;
    assign load_store = load_store_q;
    assign free_count = free_count_q;

endmodule

// File: tb/tb_rename_multi.sv
// ---------------------------------------------------------------------------
// tb_rename_multi
//
// Self-checking bench for rename_multi with default parameters (32 regs,
// 64 tags, 2 rename slots, 2 retire ports). Groups come from a vector table
// and hand-written sequences; expected group outputs are queued when a group
// is driven and popped when the registered outputs appear one cycle later.
// ---------------------------------------------------------------------------
module tb_rename_multi;

    localparam logic [6:0] OP_ADD = 7'b0110011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;

    typedef struct {
        string           name;
        logic            stall;
        logic [1:0]      valid;
        logic [1:0][6:0] op;
        logic [1:0][4:0] rd;
        logic [1:0][4:0] rs1;
        logic [1:0][4:0] rs2;
        logic            ready;
        logic [1:0][5:0] e_rd;
        logic [1:0][5:0] e_rs1;
        logic [1:0][5:0] e_rs2;
        logic [1:0][5:0] e_old;
        logic [1:0]      e_ls;
        int              e_free;
    } vec_t;

    typedef struct {
        string           name;
        logic [1:0]      valid;
        logic [1:0][5:0] t_rd;
        logic [1:0][5:0] t_rs1;
        logic [1:0][5:0] t_rs2;
        logic [1:0][5:0] t_old;
        logic [1:0]      ls;
    } exp_t;

    logic            clk;
    logic            rst;
    logic            stall_in;
    logic            flush;
    logic [1:0]      in_valid;
    logic [1:0][6:0] opcode;
    logic [1:0][4:0] rd;
    logic [1:0][4:0] rs1;
    logic [1:0][4:0] rs2;
    logic            in_ready;
    logic [1:0]      retire_valid;
    logic [1:0][4:0] retire_rd;
    logic [1:0][5:0] retire_tag;
    logic [1:0][5:0] retire_old_tag;
    logic [1:0]      out_valid;
    logic [1:0][5:0] tag_rd;
    logic [1:0][5:0] tag_rs1;
    logic [1:0][5:0] tag_rs2;
    logic [1:0][5:0] tag_old_rd;
    logic [1:0]      load_store;
    logic [6:0]      free_count;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];
    vec_t vecs[7];

    rename_multi dut (
        .clk            (clk),
        .rst            (rst),
        .stall_in       (stall_in),
        .flush          (flush),
        .in_valid       (in_valid),
        .opcode         (opcode),
        .rd             (rd),
        .rs1            (rs1),
        .rs2            (rs2),
        .in_ready       (in_ready),
        .retire_valid   (retire_valid),
        .retire_rd      (retire_rd),
        .retire_tag     (retire_tag),
        .retire_old_tag (retire_old_tag),
        .out_valid      (out_valid),
        .tag_rd         (tag_rd),
        .tag_rs1        (tag_rs1),
        .tag_rs2        (tag_rs2),
        .tag_old_rd     (tag_old_rd),
        .load_store     (load_store),
        .free_count     (free_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(input string nm, input logic [31:0] act,
                                  input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endfunction

    function automatic vec_t mkVec(
        input string nm, input logic st, input logic [1:0] v,
        input logic [6:0] op0, input int rd0, input int ra0, input int rb0,
        input logic [6:0] op1, input int rd1, input int ra1, input int rb1,
        input logic rdy,
        input int erd0, input int era0, input int erb0, input int eold0, input logic els0,
        input int erd1, input int era1, input int erb1, input int eold1, input logic els1,
        input int efree);
        vec_t x;
        x.name     = nm;
        x.stall    = st;
        x.valid    = v;
        x.op[0]    = op0;       x.op[1]    = op1;
        x.rd[0]    = 5'(rd0);   x.rd[1]    = 5'(rd1);
        x.rs1[0]   = 5'(ra0);   x.rs1[1]   = 5'(ra1);
        x.rs2[0]   = 5'(rb0);   x.rs2[1]   = 5'(rb1);
        x.ready    = rdy;
        x.e_rd[0]  = 6'(erd0);  x.e_rd[1]  = 6'(erd1);
        x.e_rs1[0] = 6'(era0);  x.e_rs1[1] = 6'(era1);
        x.e_rs2[0] = 6'(erb0);  x.e_rs2[1] = 6'(erb1);
        x.e_old[0] = 6'(eold0); x.e_old[1] = 6'(eold1);
        x.e_ls[0]  = els0;      x.e_ls[1]  = els1;
        x.e_free   = efree;
        return x;
    endfunction

    // Compare the registered group (if one is expected) and the free count.
    task automatic checkOutput(input string nm, input int efree);
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({nm, ".out_valid"}, 32'(out_valid), 32'(e.valid));
            for (int s = 0; s < 2; s++) begin
                if (e.valid[s]) begin
                    check($sformatf("%s.s%0d.tag_rd", nm, s),     32'(tag_rd[s]),     32'(e.t_rd[s]));
                    check($sformatf("%s.s%0d.tag_rs1", nm, s),    32'(tag_rs1[s]),    32'(e.t_rs1[s]));
                    check($sformatf("%s.s%0d.tag_rs2", nm, s),    32'(tag_rs2[s]),    32'(e.t_rs2[s]));
                    check($sformatf("%s.s%0d.tag_old_rd", nm, s), 32'(tag_old_rd[s]), 32'(e.t_old[s]));
                    check($sformatf("%s.s%0d.load_store", nm, s), 32'(load_store[s]), 32'(e.ls[s]));
                end
            end
        end else begin
            check({nm, ".out_valid_idle"}, 32'(out_valid), 32'd0);
        end
        check({nm, ".free_count"}, 32'(free_count), 32'(efree));
    endtask

    // Drive one group for one cycle; retire/flush are set by the caller.
    task automatic applyStimulus(input vec_t v);
        exp_t e;
        @(negedge clk);
        stall_in = v.stall;
        in_valid = v.valid;
        opcode   = v.op;
        rd       = v.rd;
        rs1      = v.rs1;
        rs2      = v.rs2;
        #1;
        check({v.name, ".in_ready"}, 32'(in_ready), 32'(v.ready));
        if (v.ready) begin
            e.name  = v.name;
            e.valid = v.valid;
            e.t_rd  = v.e_rd;
            e.t_rs1 = v.e_rs1;
            e.t_rs2 = v.e_rs2;
            e.t_old = v.e_old;
            e.ls    = v.e_ls;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        checkOutput(v.name, v.e_free);
    endtask

    task automatic clearRetire();
        retire_valid   = '0;
        retire_rd      = '0;
        retire_tag     = '0;
        retire_old_tag = '0;
        flush          = 1'b0;
    endtask

    // Assert reset in the middle of a cycle with a group on the inputs; the
    // group must be discarded and state must return to its initial values.
    task automatic doReset(input string nm);
        #2;
        rst      = 1'b0;
        in_valid = 2'b11;
        opcode   = {OP_ST, OP_LD};
        rd       = {5'd9, 5'd8};
        #1;
        check({nm, ".rst_out_valid"},  32'(out_valid),  32'd0);
        check({nm, ".rst_load_store"}, 32'(load_store), 32'd0);
        check({nm, ".rst_free_count"}, 32'(free_count), 32'd32);
        repeat (2) @(posedge clk);
        @(negedge clk);
        in_valid = '0;
        opcode   = '0;
        rd       = '0;
        rst      = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        checkOutput({nm, ".post_reset"}, 32);
    endtask

    initial begin
        vec_t v;
        int   prev;
        int   t0;

        rst      = 1'b1;
        stall_in = 1'b0;
        in_valid = '0;
        opcode   = '0;
        rd       = '0;
        rs1      = '0;
        rs2      = '0;
        clearRetire();

        vecs[0] = mkVec("v0_rs1_identity", 0, 2'b01, OP_ADD, 0, 5, 0, OP_ADD, 0, 0, 0, 1,
                        0, 5, 0, 0, 0,    0, 0, 0, 0, 0,    32);
        vecs[1] = mkVec("v1_dep_bypass", 0, 2'b11, OP_ADD, 3, 1, 2, OP_ADD, 4, 3, 3, 1,
                        32, 1, 2, 3, 0,   33, 32, 32, 4, 0, 30);
        vecs[2] = mkVec("v2_same_rd", 0, 2'b11, OP_ADD, 7, 3, 4, OP_ADD, 7, 7, 0, 1,
                        34, 32, 33, 7, 0, 35, 34, 0, 34, 0, 28);
        vecs[3] = mkVec("v3_load_store", 0, 2'b11, OP_LD, 0, 7, 3, OP_ST, 0, 7, 4, 1,
                        0, 35, 32, 0, 1,  0, 35, 33, 0, 1,  28);
        vecs[4] = mkVec("v4_empty", 0, 2'b00, OP_ADD, 0, 0, 0, OP_ADD, 0, 0, 0, 1,
                        0, 0, 0, 0, 0,    0, 0, 0, 0, 0,    28);
        vecs[5] = mkVec("v5_stall", 1, 2'b11, OP_ADD, 8, 0, 0, OP_ADD, 9, 8, 7, 0,
                        0, 0, 0, 0, 0,    0, 0, 0, 0, 0,    28);
        vecs[6] = mkVec("v6_after_stall", 0, 2'b11, OP_ADD, 8, 0, 0, OP_ADD, 9, 8, 7, 1,
                        36, 0, 0, 8, 0,   37, 36, 35, 9, 0, 26);

        doReset("reset0");

        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i]);
        end

        // Drain the pool down to a single free tag by renaming x10 repeatedly.
        prev = 10;
        for (int k = 0; k < 12; k++) begin
            t0 = 38 + 2 * k;
            v = mkVec($sformatf("drain%0d", k), 0, 2'b11, OP_ADD, 10, 0, 0, OP_ADD, 10, 0, 0, 1,
                      t0, 0, 0, prev, 0,  t0 + 1, 0, 0, t0, 0,  26 - 2 * (k + 1));
            applyStimulus(v);
            prev = t0 + 1;
        end
        v = mkVec("drain_last", 0, 2'b01, OP_ADD, 10, 0, 0, OP_ADD, 0, 0, 0, 1,
                  62, 0, 0, prev, 0,  0, 0, 0, 0, 0,  1);
        applyStimulus(v);

        // Two allocations with one free tag stall; a same-cycle retire frees
        // tag 40, which only becomes usable the cycle after.
        retire_valid      = 2'b01;
        retire_rd[0]      = 5'd3;
        retire_tag[0]     = 6'd32;
        retire_old_tag[0] = 6'd40;
        v = mkVec("starved", 0, 2'b11, OP_ADD, 11, 0, 0, OP_ADD, 12, 0, 0, 0,
                  0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  2);
        applyStimulus(v);
        clearRetire();
        v = mkVec("refilled", 0, 2'b11, OP_ADD, 11, 0, 0, OP_ADD, 12, 0, 0, 1,
                  40, 0, 0, 11, 0,  63, 0, 0, 12, 0,  0);
        applyStimulus(v);

        doReset("reset1");

        // Flush with a same-cycle retire of x5 only.
        v = mkVec("b1_rename_x5_x6", 0, 2'b11, OP_ADD, 5, 0, 0, OP_ADD, 6, 5, 0, 1,
                  32, 0, 0, 5, 0,  33, 32, 0, 6, 0,  30);
        applyStimulus(v);
        retire_valid      = 2'b01;
        retire_rd[0]      = 5'd5;
        retire_tag[0]     = 6'd32;
        retire_old_tag[0] = 6'd5;
        flush             = 1'b1;
        v = mkVec("b2_flush", 0, 2'b11, OP_ADD, 13, 0, 0, OP_ADD, 14, 0, 0, 0,
                  0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  32);
        applyStimulus(v);
        clearRetire();
        v = mkVec("b3_after_flush", 0, 2'b11, OP_ADD, 15, 5, 6, OP_ADD, 16, 15, 6, 1,
                  5, 32, 6, 15, 0,  33, 5, 6, 16, 0,  30);
        applyStimulus(v);

        // Store with rd=0 plus a retire whose old tag is 0: nothing is freed.
        retire_valid      = 2'b01;
        retire_rd[0]      = 5'd17;
        retire_tag[0]     = 6'd17;
        retire_old_tag[0] = 6'd0;
        v = mkVec("c1_store_rd0", 0, 2'b01, OP_ST, 0, 15, 16, OP_ADD, 0, 0, 0, 1,
                  0, 5, 33, 0, 1,  0, 0, 0, 0, 0,  30);
        applyStimulus(v);
        clearRetire();
        v = mkVec("c2_load_alloc", 0, 2'b01, OP_LD, 18, 0, 0, OP_ADD, 0, 0, 0, 1,
                  34, 0, 0, 18, 1,  0, 0, 0, 0, 0,  29);
        applyStimulus(v);

        // Both retire ports write x20 in the flush cycle; the later port wins.
        retire_valid      = 2'b11;
        retire_rd[0]      = 5'd20;
        retire_tag[0]     = 6'd40;
        retire_old_tag[0] = 6'd20;
        retire_rd[1]      = 5'd20;
        retire_tag[1]     = 6'd41;
        retire_old_tag[1] = 6'd40;
        flush             = 1'b1;
        v = mkVec("c3_flush_two_retire", 0, 2'b00, OP_ADD, 0, 0, 0, OP_ADD, 0, 0, 0, 0,
                  0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  32);
        applyStimulus(v);
        clearRetire();
        v = mkVec("c4_read_arch", 0, 2'b11, OP_ADD, 0, 20, 5, OP_ADD, 0, 18, 15, 1,
                  0, 41, 32, 0, 0,  0, 18, 15, 0, 0,  32);
        applyStimulus(v);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
